// File: rtl/srl16_fifo_ctrl.sv
// 16-deep FIFO on per-bit SRL16E shift registers plus write/read control.
// Define SRL_FIFO_OREG_EN for a registered read port; default is FWFT.
module srl16e_bit (
  input  logic       CLK,
  input  logic       CE,
  input  logic       D,
  input  logic [3:0] A,
  output logic       Q
);

  logic [15:0] r_sr;

  always_ff @(posedge CLK) begin
    if (CE) r_sr <= {r_sr[14:0], D};
  end

  assign Q = r_sr[A];

endmodule

module srl16_fifo_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             FULL,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             RD_VALID,
  output logic             EMPTY,
  output logic [4:0]       COUNT,
  output logic             OVF,
  output logic             UNF
);

  logic [4:0]       r_count;
  logic [3:0]       r_rd_ptr;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_unf;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_ce;
  logic [4:0]       w_cnt_nxt;
  logic [4:0]       w_cnt_dec;
  logic [3:0]       w_ptr_nxt;
  logic [WIDTH-1:0] w_q;

  assign w_rd_acc = RD_EN & ~r_empty;
  // A write at full only fits because the simultaneous pop frees slot 15.
  assign w_wr_acc = WR_EN & (~r_full | RD_EN);
  assign w_ce     = w_wr_acc & ~RST;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc & ~w_rd_acc)
      w_cnt_nxt = r_count + 5'd1;
    else if (w_rd_acc & ~w_wr_acc)
      w_cnt_nxt = r_count - 5'd1;
  end

  assign w_cnt_dec = w_cnt_nxt - 5'd1;
  assign w_ptr_nxt = (w_cnt_nxt == 5'd0) ? 4'd0 : w_cnt_dec[3:0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count  <= 5'd0;
      r_rd_ptr <= 4'd0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_count  <= w_cnt_nxt;
      r_rd_ptr <= w_ptr_nxt;
      r_full   <= (w_cnt_nxt == 5'd16);
      r_empty  <= (w_cnt_nxt == 5'd0);
      r_ovf    <= WR_EN & ~w_wr_acc;
      r_unf    <= RD_EN & ~w_rd_acc;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_srl
    srl16e_bit u_srl (
      .CLK (CLK),
      .CE  (w_ce),
      .D   (WR_DATA[i]),
      .A   (r_rd_ptr),
      .Q   (w_q[i])
    );
  end

`ifdef SRL_FIFO_OREG_EN
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= w_q;
    end
  end

  assign RD_DATA  = r_rd_data;
  assign RD_VALID = r_rd_valid;
`else
  assign RD_DATA  = w_q;
  assign RD_VALID = ~r_empty;
`endif

  assign COUNT = r_count;
  assign FULL  = r_full;
  assign EMPTY = r_empty;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

endmodule

// File: tb/tb_srl16_fifo_ctrl.sv
// Bench for srl16_fifo_ctrl: vector table, corner sequences, random run.
// Checks the FWFT or registered read port depending on SRL_FIFO_OREG_EN.
module tb_srl16_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       rd_valid;
  logic [4:0] count;
  logic       ovf;
  logic       unf;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vt[34];

  srl16_fifo_ctrl #(.WIDTH(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .WR_EN    (wr_en),
    .WR_DATA  (wr_data),
    .FULL     (full),
    .RD_EN    (rd_en),
    .RD_DATA  (rd_data),
    .RD_VALID (rd_valid),
    .EMPTY    (empty),
    .COUNT    (count),
    .OVF      (ovf),
    .UNF      (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic wr, input logic rd, input logic [7:0] d);
    logic       wacc;
    logic       racc;
    logic [7:0] exp_pop;
    exp_pop = 8'h00;
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    racc = rd && (sb.size() > 0);
    wacc = wr && ((sb.size() < 16) || rd);
    if (racc) exp_pop = sb.pop_front();
`ifndef SRL_FIFO_OREG_EN
    if (racc) chk("rd_data", {24'd0, rd_data}, {24'd0, exp_pop});
`endif
    if (wacc) sb.push_back(d);
    @(posedge clk);
    #1;
    chk("count", {27'd0, count}, sb.size());
    chk("full", {31'd0, full}, {31'd0, sb.size() == 16});
    chk("empty", {31'd0, empty}, {31'd0, sb.size() == 0});
    chk("ovf", {31'd0, ovf}, {31'd0, wr && !wacc});
    chk("unf", {31'd0, unf}, {31'd0, rd && !racc});
`ifdef SRL_FIFO_OREG_EN
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, racc});
    if (racc) chk("rd_data", {24'd0, rd_data}, {24'd0, exp_pop});
`else
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, sb.size() > 0});
`endif
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input logic wr, input logic [7:0] d);
    rst     = 1'b1;
    wr_en   = wr;
    rd_en   = 1'b0;
    wr_data = d;
    @(posedge clk);
    #1;
    sb.delete();
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_unf", {31'd0, unf}, 32'd0);
    chk("rst_valid", {31'd0, rd_valid}, 32'd0);
`ifdef SRL_FIFO_OREG_EN
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
`endif
    rst   = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      vt[i] = '{1'b1, 1'b0, 8'(i), i + 1, i == 15, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b0, 8'h10, 16, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++)
      vt[17 + i] = '{1'b0, 1'b1, 8'h00, 15 - i, 1'b0, i == 15, 1'b0, 1'b0};
    vt[33] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'h00;
    @(posedge clk);
    do_reset(1'b0, 8'h00);

    // Fill to 16, overflow, drain in order, underflow.
    for (int i = 0; i < 34; i++) begin
      cycle(vt[i].wr, vt[i].rd, vt[i].d);
      chk("tbl_count", {27'd0, count}, vt[i].cnt);
      chk("tbl_full", {31'd0, full}, {31'd0, vt[i].full});
      chk("tbl_empty", {31'd0, empty}, {31'd0, vt[i].empty});
      chk("tbl_ovf", {31'd0, ovf}, {31'd0, vt[i].ovf});
      chk("tbl_unf", {31'd0, unf}, {31'd0, vt[i].unf});
    end

    // Simultaneous write/read while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
    cycle(1'b1, 1'b1, 8'hA5);
    chk("full_wr_rd_count", {27'd0, count}, 32'd16);
    chk("full_wr_rd_ovf", {31'd0, ovf}, 32'd0);
    chk("full_wr_rd_tail", {24'd0, sb[15]}, 32'hA5);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // Simultaneous write/read while empty.
    cycle(1'b1, 1'b1, 8'h3C);
    chk("empty_wr_rd_count", {27'd0, count}, 32'd1);
    chk("empty_wr_rd_unf", {31'd0, unf}, 32'd1);
    cycle(1'b0, 1'b1, 8'h00);
    chk("empty_wr_rd_after", {27'd0, count}, 32'd0);

    // Reset with queued data and a concurrent write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h50 + 8'(i));
    do_reset(1'b1, 8'hEE);
    cycle(1'b1, 1'b0, 8'h77);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    chk("post_rst_unf", {31'd0, unf}, 32'd1);

    // Random traffic with phase-varying bias.
    for (int i = 0; i < 10000; i++) begin
      int wp;
      int rp;
      case ((i / 400) % 3)
        0:       begin wp = 80; rp = 25; end
        1:       begin wp = 25; rp = 80; end
        default: begin wp = 55; rp = 55; end
      endcase
      cycle($urandom_range(99) < wp, $urandom_range(99) < rp,
            8'($urandom_range(255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
